// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin wormhole arbiter feeding one registered output slot
module output_port_arbiter #(
  parameter int N_IN   = 5,
  parameter int FLIT_W = 16,
  parameter int IDX_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*FLIT_W-1:0] in_flit_i,
  input  logic [N_IN-1:0]        in_valid_i,
  input  logic [N_IN-1:0]        in_req_i,
  output logic [N_IN-1:0]        in_pop_o,
  output logic [FLIT_W-1:0]      out_flit_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   locked_o,
  output logic [IDX_W-1:0]       owner_o,
  output logic                   drop_o
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_d;
  logic [IDX_W-1:0] rr_ptr, rr_d, owner_d, win, sel;
  logic [N_IN-1:0] cand;
  logic can_acc, pop, bad;
  logic [FLIT_W-1:0] flit;
  logic [1:0] ftype;
  assign can_acc  = !out_valid_o || out_ready_i;
  assign cand     = in_valid_i & in_req_i;
  assign locked_o = state == LOCKED;
  // descending scan so the candidate closest after rr_ptr is written last
  always_comb begin
    win = '0;
    for (int i = N_IN; i >= 1; i--)
      if (cand[(int'(rr_ptr) + i) % N_IN]) win = IDX_W'((int'(rr_ptr) + i) % N_IN);
  end
  assign sel      = locked_o ? owner_o : win;
  assign pop      = can_acc && (locked_o ? in_valid_i[owner_o] : |cand);
  assign flit     = in_flit_i[int'(sel)*FLIT_W +: FLIT_W];
  assign ftype    = flit[FLIT_W-1 -: 2];
  assign bad      = locked_o ? ftype[1] == ftype[0] : ftype[1] ^ ftype[0];
  assign in_pop_o = pop ? N_IN'(1) << sel : '0;
  always_comb begin
    state_d = state;
    owner_d = owner_o;
    rr_d    = rr_ptr;
    if (pop && !locked_o) begin
      if (ftype == 2'b00) begin
        state_d = LOCKED;
        owner_d = win;
      end else rr_d = win;
    end else if (pop && ftype == 2'b10) begin
      state_d = IDLE;
      rr_d    = owner_o;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner_o     <= '0;
      rr_ptr      <= IDX_W'(N_IN - 1);
      out_flit_o  <= '0;
      out_valid_o <= 1'b0;
      drop_o      <= 1'b0;
    end else begin
      state   <= state_d;
      owner_o <= owner_d;
      rr_ptr  <= rr_d;
      drop_o  <= pop && bad;
      if (pop && !bad) begin
        out_flit_o  <= flit;
        out_valid_o <= 1'b1;
      end else if (out_ready_i) out_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed table, queue-driven sequences and random traffic vs a reference model
module tb_output_port_arbiter;
  logic clk = 0, rst = 1;
  logic [79:0] in_flit_i = '0;
  logic [4:0] in_valid_i = '0, in_req_i = '0, in_pop_o;
  logic [15:0] out_flit_o;
  logic out_valid_o, out_ready_i = 0, locked_o, drop_o;
  logic [2:0] owner_o;

  output_port_arbiter dut (.clk(clk), .rst(rst), .in_flit_i(in_flit_i), .in_valid_i(in_valid_i),
    .in_req_i(in_req_i), .in_pop_o(in_pop_o), .out_flit_o(out_flit_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .locked_o(locked_o), .owner_o(owner_o), .drop_o(drop_o));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int m_ptr, m_owner, last_w;
  bit m_lock, m_val, m_drop;
  logic [15:0] m_flit;
  logic [4:0] last_pop;
  logic [15:0] tbq[5][$];
  logic [15:0] delivered[$];

  typedef struct {
    logic [4:0] v, r;
    logic [15:0] f;
    logic rdy;
    logic [4:0] pop;
    logic [15:0] oflit;
    logic oval, lock, drop;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 4; m_owner = 0; m_lock = 0; m_val = 0; m_drop = 0; m_flit = '0;
  endtask

  task automatic do_reset();
    in_valid_i = '0; in_req_i = '0; out_ready_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_flit", out_flit_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_owner", owner_o, 0);
    chk("rst_drop", drop_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) tbq[k].delete();
  endtask

  // one clock: drive, check pop against model, clock, check registered outputs
  task automatic apply(input logic [4:0] v, input logic [4:0] r, input logic [79:0] fl, input logic rdy);
    int w;
    int order[$];
    logic [15:0] wf;
    logic [1:0] t;
    bit err;
    in_valid_i = v; in_req_i = r; in_flit_i = fl; out_ready_i = rdy;
    #1;
    w = -1;
    if (!m_val || rdy) begin
      if (m_lock) begin
        if (v[m_owner]) w = m_owner;
      end else begin
        for (int i = 1; i <= 5; i++) order.push_back((m_ptr + i) % 5);
        foreach (order[j]) if (w < 0 && v[order[j]] && r[order[j]]) w = order[j];
      end
    end
    last_pop = in_pop_o;
    last_w = w;
    chk("pop", in_pop_o, w < 0 ? 0 : (1 << w));
    if (m_val && rdy) delivered.push_back(m_flit);
    @(posedge clk); #1;
    m_drop = 0;
    if (w >= 0) begin
      wf = fl[w*16 +: 16];
      t = wf[15:14];
      if (m_lock) begin
        err = (t == 2'b00) || (t == 2'b11);
        if (t == 2'b10) begin m_lock = 0; m_ptr = m_owner; end
      end else begin
        err = (t == 2'b01) || (t == 2'b10);
        if (t == 2'b00) begin m_lock = 1; m_owner = w; end
        else m_ptr = w;
      end
      m_drop = err;
      if (!err) begin m_flit = wf; m_val = 1; end
      else if (rdy) m_val = 0;
    end else if (rdy) m_val = 0;
    chk("out_valid", out_valid_o, m_val);
    chk("out_flit", out_flit_o, m_flit);
    chk("locked", locked_o, m_lock);
    chk("drop", drop_o, m_drop);
    if (m_lock) chk("owner", owner_o, m_owner);
  endtask

  task automatic qcyc(input logic rdy);
    logic [4:0] v;
    logic [79:0] fl;
    v = '0; fl = '0;
    for (int k = 0; k < 5; k++)
      if (tbq[k].size() > 0) begin v[k] = 1'b1; fl[k*16 +: 16] = tbq[k][0]; end
    apply(v, 5'h1f, fl, rdy);
    if (last_w >= 0) void'(tbq[last_w].pop_front());
  endtask

  function automatic bit queues_empty();
    for (int k = 0; k < 5; k++) if (tbq[k].size() > 0) return 0;
    return 1;
  endfunction

  initial begin
    logic [15:0] hold, exp_seq[$];
    logic [79:0] fl;
    int prev;
    vecs[0] = '{5'b00100, 5'b00100, 16'hC0AA, 1'b1, 5'b00100, 16'hC0AA, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{5'b00010, 5'b00010, 16'h4055, 1'b1, 5'b00010, 16'hC0AA, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{5'b00000, 5'b00000, 16'h0000, 1'b1, 5'b00000, 16'hC0AA, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{5'b01000, 5'b00000, 16'hC0BB, 1'b1, 5'b00000, 16'hC0AA, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{5'b00000, 5'b01000, 16'hC0BB, 1'b1, 5'b00000, 16'hC0AA, 1'b0, 1'b0, 1'b0};
    do_reset();
    foreach (vecs[i]) begin
      apply(vecs[i].v, vecs[i].r, {5{vecs[i].f}}, vecs[i].rdy);
      chk("tbl_pop", last_pop, vecs[i].pop);
      chk("tbl_flit", out_flit_o, vecs[i].oflit);
      chk("tbl_valid", out_valid_o, vecs[i].oval);
      chk("tbl_lock", locked_o, vecs[i].lock);
      chk("tbl_drop", drop_o, vecs[i].drop);
    end

    // two simultaneous packets: input 0 wins after reset, no interleaving
    do_reset();
    delivered.delete();
    tbq[0] = '{16'h0011, 16'h4022, 16'h8033};
    tbq[3] = '{16'h0011, 16'h4022, 16'h8033};
    for (int c = 0; c < 8; c++) begin
      qcyc(1'b1);
      if (c < 2) begin
        chk("pkt_locked", locked_o, 1);
        chk("pkt_owner", owner_o, 0);
      end
      if (c == 3) chk("pkt_owner3", owner_o, 3);
    end
    exp_seq = '{16'h0011, 16'h4022, 16'h8033, 16'h0011, 16'h4022, 16'h8033};
    chk("pkt_count", delivered.size(), 6);
    foreach (exp_seq[i]) chk("pkt_order", i < delivered.size() ? delivered[i] : 16'hxxxx, exp_seq[i]);

    // continuous singles on inputs 1 and 4 must alternate
    for (int i = 0; i < 8; i++) begin
      tbq[1].push_back(16'hC100 + 16'(i));
      tbq[4].push_back(16'hC400 + 16'(i));
    end
    prev = -1;
    for (int c = 0; c < 8; c++) begin
      qcyc(1'b1);
      if (prev >= 0) begin
        chk("alt_switch", last_w != prev, 1);
        chk("alt_valid", out_valid_o, 1);
      end
      prev = last_w;
    end
    for (int c = 0; c < 20 && !queues_empty(); c++) qcyc(1'b1);
    qcyc(1'b1);
    chk("alt_drained", queues_empty(), 1);

    // back-pressure mid-packet
    delivered.delete();
    tbq[2] = '{16'h0012, 16'h4012, 16'h4013, 16'h8014};
    qcyc(1'b1);
    qcyc(1'b1);
    hold = out_flit_o;
    for (int c = 0; c < 3; c++) begin
      qcyc(1'b0);
      chk("bp_pop", last_pop, 0);
      chk("bp_stable", out_flit_o, hold);
      chk("bp_valid", out_valid_o, 1);
    end
    for (int c = 0; c < 6; c++) qcyc(1'b1);
    exp_seq = '{16'h0012, 16'h4012, 16'h4013, 16'h8014};
    chk("bp_count", delivered.size(), 4);
    foreach (exp_seq[i]) chk("bp_order", i < delivered.size() ? delivered[i] : 16'hxxxx, exp_seq[i]);

    // reset in the middle of a packet
    tbq[3] = '{16'h0077, 16'h4077, 16'h8077};
    qcyc(1'b1);
    qcyc(1'b1);
    chk("mid_locked_pre", locked_o, 1);
    do_reset();
    apply(5'h1f, 5'h1f, {5{16'hC0EE}}, 1'b1);
    chk("mid_first_grant", last_pop, 5'b00001);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      fl = '0;
      for (int k = 0; k < 5; k++) fl[k*16 +: 16] = 16'($urandom);
      apply(5'($urandom), 5'($urandom), fl, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- One instance per router output (north, south, east, west, local).
- Sits directly downstream of the input queue buffers. It takes the head-of-queue flits of all five input queues and grants one input per packet, using round-robin arbitration with wormhole locking.
- The granted flit goes into a single registered output slot. That slot drives the router output port with a valid/ready handshake.

Parameters:
- N_IN, 5, number of input queues competing for this output.
- FLIT_W, 16, flit width in bits.
- IDX_W, 3, width of the input index (ceil(log2(N_IN))).

Ports:
- clk  input  1  router clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_flit_i  input  N_IN*FLIT_W  head-of-queue flits; input k occupies bits [k*FLIT_W +: FLIT_W].
- in_valid_i  input  N_IN  queue k is non-empty and in_flit_i slice k is valid.
- in_req_i  input  N_IN  route compute says the head flit of queue k targets this output.
- in_pop_o  output  N_IN  one-hot; the flit of queue k is consumed this cycle and the queue must dequeue.
- out_flit_o  output  FLIT_W  registered output flit.
- out_valid_o  output  1  out_flit_o holds a valid flit.
- out_ready_i  input  1  downstream accepts out_flit_o this cycle.
- locked_o  output  1  a packet currently owns this output.
- owner_o  output  IDX_W  index of the owning input (valid while locked_o=1).
- drop_o  output  1  one-cycle pulse when a protocol-violating flit is discarded.

Behaviour:
- Flit type field is flit[15:14]:
  - 00 = head
  - 01 = body
  - 10 = tail
  - 11 = single-flit packet
- Reset (asynchronous, immediate):
  - out_valid_o=0, out_flit_o=0, locked_o=0, owner_o=0, drop_o=0.
  - FSM goes to IDLE.
  - rr_ptr=N_IN-1, so input 0 has highest priority first.
  - Reset mid-packet abandons the lock and loses any flit held in the output slot.
- Output slot accept condition: can_acc = !out_valid_o || out_ready_i. Full throughput is one flit per cycle.
- Output slot update on a clock edge:
  - If a flit is popped (and not dropped): out_flit_o <= that flit and out_valid_o <= 1.
  - Else if out_ready_i: out_valid_o <= 0.
  - Latency from pop to out_valid_o is 1 cycle.
- FSM state IDLE:
  - Candidates are inputs k with in_valid_i[k] && in_req_i[k].
  - If can_acc and a candidate exists, the winner is the first candidate scanning from rr_ptr+1 with wrap-around modulo N_IN.
  - The winner is popped.
  - Winner type head: go to LOCKED, owner_o <= winner, locked_o <= 1.
  - Winner type single: stay in IDLE, rr_ptr <= winner.
  - Winner type body or tail (protocol error): the flit is popped but not written to the slot. drop_o pulses for one cycle, FSM stays in IDLE, rr_ptr <= winner.
- FSM state LOCKED:
  - Only the owner is considered; in_req_i is ignored because the route is fixed by the head flit.
  - Pop the owner when in_valid_i[owner] && can_acc.
  - Body: stay in LOCKED.
  - Tail: go to IDLE, locked_o <= 0, rr_ptr <= owner.
  - Head or single (error): drop it, pulse drop_o, stay in LOCKED.
- Non-owner inputs are never popped while LOCKED, regardless of their valid or request.
- in_pop_o is combinational and at most one-hot. It is never asserted when can_acc=0.
- Back-pressure: if out_ready_i=0 while out_valid_o=1, out_flit_o and out_valid_o hold stable. No pop occurs, and the FSM and rr_ptr do not change.
- The owner's queue running empty mid-packet does not release the lock; the lock waits for the tail.

Test Plan:
- Reset, then input 2 presents a single flit 0xC0AA with req=1 and out_ready=1 → in_pop_o=5'b00100 in the same cycle; next cycle out_flit_o=0xC0AA, out_valid_o=1, locked_o=0.
- Inputs 0 and 3 each send a 3-flit packet (0x0011 head, 0x4022 body, 0x8033 tail) simultaneously → input 0 wins after reset. Output order is 0x0011, 0x4022, 0x8033 from input 0, then input 3's packet. No interleaving; locked_o=1 with owner_o=0 throughout the first packet.
- Inputs 1 and 4 send continuous single flits with always ready → grants alternate 1,4,1,4; out_valid_o is 1 every cycle after the first.
- Mid-packet, hold out_ready_i=0 for 3 cycles → out_flit_o is stable, in_pop_o=0, and after release the flit sequence is intact with no duplicates.
- In IDLE, present a body flit 0x4055 on input 1 → pop, drop_o=1 for one cycle, out_valid_o stays 0.
- Assert rst for one cycle mid-packet (after head, before tail) → locked_o=0 and out_valid_o=0 immediately; the next arbitration starts from input 0.
